// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline. It drives the pipeline-register enables,
// flushes and holds, selects the EX-stage forwarding paths, and counts stalls and flushes.
module pipe_hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic [4:0]       ID_EX_Rs,
    input  logic [4:0]       ID_EX_Rt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       EX_MEM_Rd,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_PCSrc,
    input  logic [4:0]       MEM_WB_Rd,
    input  logic             MEM_WB_RegWrite,
    input  logic             mem_busy,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             pipe_hold,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t              r_state;
    state_t              r_ret_state;
    state_t              w_state_next;
    state_t              w_ret_next;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_inc;
    logic                r_mem_timeout;
    logic                w_load_use;
    logic                w_stall_inc;
    logic                w_flush_inc;
    logic [1:0][4:0]     w_ex_src;
    logic [1:0][1:0]     w_fwd;

    // Load in EX whose destination is read by the instruction sitting in ID.
    assign w_load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                        ((ID_EX_Rt == IF_ID_Rs) ||
                         (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

    assign w_ex_src[0] = ID_EX_Rs;
    assign w_ex_src[1] = ID_EX_Rt;

    // The youngest producer (EX/MEM) takes precedence over MEM/WB.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic w_ex_hit;
            logic w_wb_hit;
            assign w_ex_hit = EX_MEM_RegWrite && (EX_MEM_Rd != 5'd0) &&
                              (EX_MEM_Rd == w_ex_src[gi]);
            assign w_wb_hit = MEM_WB_RegWrite && (MEM_WB_Rd != 5'd0) &&
                              (MEM_WB_Rd == w_ex_src[gi]);
            assign w_fwd[gi] = rst      ? 2'b00 :
                               w_ex_hit ? 2'b10 :
                               w_wb_hit ? 2'b01 : 2'b00;
        end
    endgenerate

    assign ForwardA = w_fwd[0];
    assign ForwardB = w_fwd[1];

    always_comb begin
        w_state_next = r_state;
        w_ret_next   = r_ret_state;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        pipe_hold    = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;

        if (rst) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            w_state_next = ST_RUN;
            w_ret_next   = ST_RUN;
        end else if (mem_busy) begin
            // Whole pipe freezes; branch and load-use are still visible afterwards.
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            pipe_hold    = 1'b1;
            w_stall_inc  = 1'b1;
            w_state_next = ST_MEM_WAIT;
            if (r_state != ST_MEM_WAIT) begin
                w_ret_next = r_state;
            end
        end else if (EX_MEM_PCSrc) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            w_flush_inc  = 1'b1;
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_load_use) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Flush  = 1'b1;
                        w_stall_inc  = 1'b1;
                        w_state_next = ST_LU_STALL;
                    end
                end
                ST_LU_STALL: w_state_next = ST_RUN;
                ST_MEM_WAIT: w_state_next = r_ret_state;
                default:     w_state_next = ST_RUN;
            endcase
        end
    end

    assign w_wait_inc = r_wait_cnt + WAIT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_ret_state   <= ST_RUN;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ret_state <= w_ret_next;
            if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
            // Watchdog only measures the current unbroken run of busy cycles.
            if (mem_busy) begin
                if (r_wait_cnt != WAIT_LIMIT) begin
                    r_wait_cnt <= w_wait_inc;
                end
                if (w_wait_inc == WAIT_LIMIT) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign mem_timeout = r_mem_timeout;
    assign state       = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a behavioural model,
// driving a default-sized instance and a small one (CNT_W=2, MAX_WAIT=4) in parallel.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, EX_MEM_Rd, MEM_WB_Rd;
    logic       IF_ID_UsesRt, ID_EX_MemRead, EX_MEM_RegWrite, EX_MEM_PCSrc;
    logic       MEM_WB_RegWrite, mem_busy;

    logic        b_pcw, b_ifw, b_iff, b_idf, b_exf, b_hold, b_to;
    logic [1:0]  b_fa, b_fb, b_state;
    logic [15:0] b_stall, b_flush;
    logic        s_pcw, s_ifw, s_iff, s_idf, s_exf, s_hold, s_to;
    logic [1:0]  s_fa, s_fb, s_state;
    logic [1:0]  s_stall, s_flush;

    pipe_hazard_ctrl dut_big (
        .clk(clk), .rst(rst),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
        .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_MemRead(ID_EX_MemRead),
        .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_PCSrc(EX_MEM_PCSrc),
        .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite), .mem_busy(mem_busy),
        .PCWrite(b_pcw), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_iff), .ID_EX_Flush(b_idf),
        .EX_MEM_Flush(b_exf), .pipe_hold(b_hold), .ForwardA(b_fa), .ForwardB(b_fb),
        .stall_cnt(b_stall), .flush_cnt(b_flush), .mem_timeout(b_to), .state(b_state)
    );

    pipe_hazard_ctrl #(.CNT_W(2), .MAX_WAIT(4)) dut_small (
        .clk(clk), .rst(rst),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
        .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_MemRead(ID_EX_MemRead),
        .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_PCSrc(EX_MEM_PCSrc),
        .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite), .mem_busy(mem_busy),
        .PCWrite(s_pcw), .IF_ID_Write(s_ifw), .IF_ID_Flush(s_iff), .ID_EX_Flush(s_idf),
        .EX_MEM_Flush(s_exf), .pipe_hold(s_hold), .ForwardA(s_fa), .ForwardB(s_fb),
        .stall_cnt(s_stall), .flush_cnt(s_flush), .mem_timeout(s_to), .state(s_state)
    );

    // Control word: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, pipe_hold, FwdA, FwdB}
    logic [9:0] obs_b, obs_s;
    assign obs_b = {b_pcw, b_ifw, b_iff, b_idf, b_exf, b_hold, b_fa, b_fb};
    assign obs_s = {s_pcw, s_ifw, s_iff, s_idf, s_exf, s_hold, s_fa, s_fb};

    localparam logic [9:0] C_RESET = {2'b00, 3'b111, 1'b0, 4'b0000};
    localparam logic [9:0] C_RUN   = {2'b11, 3'b000, 1'b0, 4'b0000};
    localparam logic [9:0] C_LU    = {2'b00, 3'b010, 1'b0, 4'b0000};
    localparam logic [9:0] C_BR    = {2'b11, 3'b111, 1'b0, 4'b0000};
    localparam logic [9:0] C_BUSY  = {2'b00, 3'b000, 1'b1, 4'b0000};

    int checks = 0;
    int errors = 0;

    // Behavioural model: "just stalled", "frozen", "was stalled when frozen", event tallies.
    bit         m_lu, m_frozen, m_ret_lu, m_to_b, m_to_s, m_hazard;
    int         m_stall, m_flush, m_run;
    logic [9:0] e_ctl;

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_post();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IF_ID_Rs = 0; IF_ID_Rt = 0; IF_ID_UsesRt = 0;
        ID_EX_Rs = 0; ID_EX_Rt = 0; ID_EX_MemRead = 0;
        EX_MEM_Rd = 0; EX_MEM_RegWrite = 0; EX_MEM_PCSrc = 0;
        MEM_WB_Rd = 0; MEM_WB_RegWrite = 0; mem_busy = 0;
    endtask

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (EX_MEM_RegWrite && EX_MEM_Rd != 0 && EX_MEM_Rd == src) return 2'b10;
        if (MEM_WB_RegWrite && MEM_WB_Rd != 0 && MEM_WB_Rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_comb();
        m_hazard = ID_EX_MemRead && ID_EX_Rt != 0 &&
                   (ID_EX_Rt == IF_ID_Rs || (IF_ID_UsesRt && ID_EX_Rt == IF_ID_Rt));
        if (rst) e_ctl = C_RESET;
        else begin
            if (mem_busy) e_ctl = C_BUSY;
            else if (EX_MEM_PCSrc) e_ctl = C_BR;
            else if (m_hazard && !m_lu && !m_frozen) e_ctl = C_LU;
            else e_ctl = C_RUN;
            e_ctl[3:2] = fwd_sel(ID_EX_Rs);
            e_ctl[1:0] = fwd_sel(ID_EX_Rt);
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            m_lu = 0; m_frozen = 0; m_ret_lu = 0; m_to_b = 0; m_to_s = 0;
            m_stall = 0; m_flush = 0; m_run = 0;
        end else begin
            if (mem_busy) begin
                m_stall++;
                if (!m_frozen) m_ret_lu = m_lu;
                m_frozen = 1; m_lu = 0;
            end else if (EX_MEM_PCSrc) begin
                m_flush++;
                m_frozen = 0; m_lu = 0;
            end else if (m_frozen) begin
                m_frozen = 0; m_lu = m_ret_lu;
            end else if (m_lu) begin
                m_lu = 0;
            end else if (m_hazard) begin
                m_stall++;
                m_lu = 1;
            end
            m_run = mem_busy ? m_run + 1 : 0;
            if (m_run >= 64) m_to_b = 1;
            if (m_run >= 4)  m_to_s = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        mem_busy = 1; EX_MEM_PCSrc = 1;
        EX_MEM_RegWrite = 1; EX_MEM_Rd = 5; ID_EX_Rs = 5;
        ID_EX_MemRead = 1; ID_EX_Rt = 8; IF_ID_Rs = 8;
        for (int i = 0; i < 2; i++) begin
            to_neg();
            checks++;
            if (obs_b !== C_RESET) begin errors++; $display("FAIL reset_ctl cyc=%0d got %b want %b", i, obs_b, C_RESET); end
            to_post();
            checks++;
            if ({b_state, b_stall, b_flush, b_to} !== 35'd0) begin
                errors++; $display("FAIL reset_regs cyc=%0d state=%0d stall=%0d flush=%0d to=%0b want all 0", i, b_state, b_stall, b_flush, b_to);
            end
        end
        rst = 0; clear_inputs();
        to_neg();
        checks++;
        if (obs_b !== C_RUN) begin errors++; $display("FAIL reset_release_ctl got %b want %b", obs_b, C_RUN); end
        to_post();
        checks++;
        if (b_state !== 2'd0) begin errors++; $display("FAIL reset_release_state got %0d want 0", b_state); end
    endtask

    task automatic test_load_use();
        ID_EX_MemRead = 1; ID_EX_Rt = 8; IF_ID_Rs = 8;
        to_neg();
        checks++;
        if (obs_b !== C_LU) begin errors++; $display("FAIL lu_c1_ctl got %b want %b", obs_b, C_LU); end
        to_post();
        checks++;
        if (b_state !== 2'd1 || b_stall !== 16'd1) begin errors++; $display("FAIL lu_c1_regs state=%0d stall=%0d want 1/1", b_state, b_stall); end
        to_neg();
        checks++;
        if (obs_b !== C_RUN) begin errors++; $display("FAIL lu_c2_ctl got %b want %b", obs_b, C_RUN); end
        to_post();
        checks++;
        if (b_state !== 2'd0 || b_stall !== 16'd1) begin errors++; $display("FAIL lu_c2_regs state=%0d stall=%0d want 0/1", b_state, b_stall); end
        ID_EX_Rt = 0; IF_ID_Rs = 0;
        to_neg();
        checks++;
        if (obs_b !== C_RUN) begin errors++; $display("FAIL lu_rt0_ctl got %b want %b", obs_b, C_RUN); end
        to_post();
        checks++;
        if (b_state !== 2'd0 || b_stall !== 16'd1) begin errors++; $display("FAIL lu_rt0_regs state=%0d stall=%0d want 0/1", b_state, b_stall); end
        ID_EX_Rt = 8; IF_ID_Rs = 3; IF_ID_Rt = 8; IF_ID_UsesRt = 0;
        to_neg();
        checks++;
        if (obs_b !== C_RUN) begin errors++; $display("FAIL lu_norr_ctl got %b want %b", obs_b, C_RUN); end
        to_post();
        IF_ID_UsesRt = 1;
        to_neg();
        checks++;
        if (obs_b !== C_LU) begin errors++; $display("FAIL lu_rt_ctl got %b want %b", obs_b, C_LU); end
        to_post();
        checks++;
        if (b_state !== 2'd1 || b_stall !== 16'd2) begin errors++; $display("FAIL lu_rt_regs state=%0d stall=%0d want 1/2", b_state, b_stall); end
        clear_inputs();
        to_post();
    endtask

    task automatic test_branch();
        ID_EX_MemRead = 1; ID_EX_Rt = 8; IF_ID_Rs = 8; EX_MEM_PCSrc = 1;
        to_neg();
        checks++;
        if (obs_b !== C_BR) begin errors++; $display("FAIL br_ctl got %b want %b", obs_b, C_BR); end
        to_post();
        checks++;
        if (b_state !== 2'd0 || b_stall !== 16'd2 || b_flush !== 16'd1) begin
            errors++; $display("FAIL br_regs state=%0d stall=%0d flush=%0d want 0/2/1", b_state, b_stall, b_flush);
        end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        ID_EX_MemRead = 1; ID_EX_Rt = 9; IF_ID_Rs = 9;
        to_post();
        checks++;
        if (b_state !== 2'd1 || b_stall !== 16'd3) begin errors++; $display("FAIL mw_enter state=%0d stall=%0d want 1/3", b_state, b_stall); end
        clear_inputs();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            EX_MEM_PCSrc = (i == 1);
            to_neg();
            checks++;
            if (obs_b !== C_BUSY) begin errors++; $display("FAIL mw_busy_ctl cyc=%0d got %b want %b", i, obs_b, C_BUSY); end
            to_post();
            checks++;
            if (b_state !== 2'd2 || b_stall !== 16'(4 + i) || b_flush !== 16'd1) begin
                errors++; $display("FAIL mw_busy_regs cyc=%0d state=%0d stall=%0d flush=%0d want 2/%0d/1", i, b_state, b_stall, b_flush, 4 + i);
            end
        end
        mem_busy = 0; EX_MEM_PCSrc = 0;
        to_neg();
        checks++;
        if (obs_b !== C_RUN) begin errors++; $display("FAIL mw_release_ctl got %b want %b", obs_b, C_RUN); end
        to_post();
        checks++;
        if (b_state !== 2'd1) begin errors++; $display("FAIL mw_return state=%0d want 1", b_state); end
        to_post();
        checks++;
        if (b_state !== 2'd0 || b_stall !== 16'd6) begin errors++; $display("FAIL mw_run state=%0d stall=%0d want 0/6", b_state, b_stall); end
    endtask

    task automatic test_forwarding();
        EX_MEM_Rd = 5; EX_MEM_RegWrite = 1; MEM_WB_Rd = 5; MEM_WB_RegWrite = 1;
        ID_EX_Rs = 5; ID_EX_Rt = 5;
        to_neg();
        checks++;
        if ({b_fa, b_fb} !== 4'b1010) begin errors++; $display("FAIL fwd_both got %b want 1010", {b_fa, b_fb}); end
        EX_MEM_RegWrite = 0;
        to_neg();
        checks++;
        if ({b_fa, b_fb} !== 4'b0101) begin errors++; $display("FAIL fwd_wb got %b want 0101", {b_fa, b_fb}); end
        ID_EX_Rt = 7; MEM_WB_Rd = 7; EX_MEM_RegWrite = 1;
        to_neg();
        checks++;
        if ({b_fa, b_fb} !== 4'b1001) begin errors++; $display("FAIL fwd_split got %b want 1001", {b_fa, b_fb}); end
        EX_MEM_Rd = 0; MEM_WB_Rd = 0; ID_EX_Rs = 0; ID_EX_Rt = 0;
        to_neg();
        checks++;
        if ({b_fa, b_fb} !== 4'b0000) begin errors++; $display("FAIL fwd_r0 got %b want 0000", {b_fa, b_fb}); end
        clear_inputs();
        to_post();
    endtask

    task automatic test_watchdog();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) to_post();
        mem_busy = 0;
        to_post();
        checks++;
        if ({b_to, s_to} !== 2'b00) begin errors++; $display("FAIL wd_short got %b want 00", {b_to, s_to}); end
        mem_busy = 1;
        for (int i = 1; i <= 64; i++) begin
            to_post();
            checks++;
            if ({b_to, s_to} !== {i >= 64, i >= 4}) begin
                errors++; $display("FAIL wd_run cyc=%0d got %b want %b", i, {b_to, s_to}, {i >= 64, i >= 4});
            end
        end
        mem_busy = 0;
        to_post();
        to_post();
        checks++;
        if ({b_to, s_to, b_state} !== 4'b1100) begin errors++; $display("FAIL wd_sticky got %b want 1100", {b_to, s_to, b_state}); end
    endtask

    task automatic test_saturation();
        rst = 1; clear_inputs();
        to_post();
        rst = 0;
        for (int k = 1; k <= 5; k++) begin
            ID_EX_MemRead = 1; ID_EX_Rt = 4; IF_ID_Rs = 4;
            to_post();
            ID_EX_MemRead = 0;
            to_post();
            checks++;
            if (s_stall !== 2'(sat(k, 2)) || b_stall !== 16'(k)) begin
                errors++; $display("FAIL sat_stall k=%0d small=%0d big=%0d want %0d/%0d", k, s_stall, b_stall, sat(k, 2), k);
            end
        end
        clear_inputs();
        EX_MEM_PCSrc = 1;
        for (int k = 1; k <= 5; k++) begin
            to_post();
            checks++;
            if (s_flush !== 2'(sat(k, 2)) || b_flush !== 16'(k)) begin
                errors++; $display("FAIL sat_flush k=%0d small=%0d big=%0d want %0d/%0d", k, s_flush, b_flush, sat(k, 2), k);
            end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst             = (n == 0) || ($urandom_range(99) == 0);
            IF_ID_Rs        = 5'($urandom_range(3));
            IF_ID_Rt        = 5'($urandom_range(3));
            IF_ID_UsesRt    = 1'($urandom_range(1));
            ID_EX_Rs        = 5'($urandom_range(3));
            ID_EX_Rt        = 5'($urandom_range(3));
            ID_EX_MemRead   = 1'($urandom_range(1));
            EX_MEM_Rd       = 5'($urandom_range(3));
            EX_MEM_RegWrite = 1'($urandom_range(1));
            EX_MEM_PCSrc    = ($urandom_range(7) == 0);
            MEM_WB_Rd       = 5'($urandom_range(3));
            MEM_WB_RegWrite = 1'($urandom_range(1));
            mem_busy        = mem_busy ? ($urandom_range(9) < 8) : ($urandom_range(9) < 2);
            model_comb();
            to_neg();
            checks++;
            if (obs_b !== e_ctl) begin errors++; $display("FAIL rnd_ctl_big n=%0d got %b want %b", n, obs_b, e_ctl); end
            checks++;
            if (obs_s !== e_ctl) begin errors++; $display("FAIL rnd_ctl_small n=%0d got %b want %b", n, obs_s, e_ctl); end
            to_post();
            model_clock();
            checks++;
            if (b_state !== (m_frozen ? 2'd2 : (m_lu ? 2'd1 : 2'd0)) || s_state !== b_state) begin
                errors++; $display("FAIL rnd_state n=%0d big=%0d small=%0d want %0d", n, b_state, s_state, m_frozen ? 2 : (m_lu ? 1 : 0));
            end
            checks++;
            if (b_stall !== 16'(sat(m_stall, 16)) || s_stall !== 2'(sat(m_stall, 2))) begin
                errors++; $display("FAIL rnd_stall n=%0d big=%0d small=%0d want %0d", n, b_stall, s_stall, m_stall);
            end
            checks++;
            if (b_flush !== 16'(sat(m_flush, 16)) || s_flush !== 2'(sat(m_flush, 2))) begin
                errors++; $display("FAIL rnd_flush n=%0d big=%0d small=%0d want %0d", n, b_flush, s_flush, m_flush);
            end
            checks++;
            if ({b_to, s_to} !== {m_to_b, m_to_s}) begin
                errors++; $display("FAIL rnd_timeout n=%0d got %b want %b", n, {b_to, s_to}, {m_to_b, m_to_s});
            end
        end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_forwarding();
        test_watchdog();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
